param_ring_buffer: RTL
======================

PARAM_RING_BUFFER -- requirements
Module: param_ring_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 128, entry count; power of two, >= 4.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries.
REQ-005 The block SHALL have parameter FWFT, default 0, read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 wen  input  1  write request.
REQ-009 ren  input  1  read request.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 clr_err  input  1  clears sticky error flags.
REQ-012 dout  output  DATA_WIDTH  read data.
REQ-013 dout_valid  output  1  dout carries a valid popped or head word.
REQ-014 full_flag  output  1  count == DEPTH.
REQ-015 empty_flag  output  1  count == 0.
REQ-016 almost_full  output  1  count >= AFULL_TH.
REQ-017 almost_empty  output  1  count <= AEMPTY_TH.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-019 overflow  output  1  sticky: write rejected because full.
REQ-020 underflow  output  1  sticky: read rejected because empty.

Function
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits, wrap from DEPTH-1 to 0 with no gap.
REQ-022 A write SHALL be accepted iff wen=1 and full_flag=0 at the edge; accepted write stores din at wptr, then wptr+1.
REQ-023 A read SHALL be accepted iff ren=1 and empty_flag=0 at the edge; accepted read advances rptr+1.
REQ-024 Accepted write and read in the same cycle SHALL both occur; count unchanged.
REQ-025 count SHALL update next edge: +1 write-only, -1 read-only, unchanged otherwise; never exceeds DEPTH or drops below 0.
REQ-026 full_flag, empty_flag, almost_full, almost_empty SHALL be pure functions of registered count, valid the cycle count updates.
REQ-027 wen=1 while full_flag=1 SHALL not write, not move wptr, and set overflow next edge, even if ren is accepted same cycle.
REQ-028 ren=1 while empty_flag=1 SHALL not move rptr and set underflow next edge, even if wen is accepted same cycle.
REQ-029 overflow/underflow SHALL hold until clr_err=1 clears them next edge; new error in the clr_err cycle wins (flag stays 1).
REQ-030 FWFT=0: dout SHALL register mem[rptr] on an accepted read, visible one cycle later with dout_valid=1 for exactly that cycle; dout holds last value otherwise.
REQ-031 FWFT=1: dout SHALL equal head entry mem[rptr] and dout_valid SHALL equal !empty_flag; accepted read pops head, next entry appears following cycle.
REQ-032 FWFT=1 write into empty buffer SHALL make the word visible on dout one cycle after the write edge.
REQ-033 Storage SHALL be inferable RAM with no reset on contents.

Reset
REQ-034 rst_n=0 at an edge SHALL set wptr=0, rptr=0, count=0, empty_flag=1, full_flag=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0, dout_valid=0.
REQ-035 Reset SHALL override wen, ren, clr_err in the same cycle; contents after mid-operation reset are discarded (buffer reads empty).

Verification
REQ-036 DEPTH=8, FWFT=0: write 1..5, then 5 reads -> dout 1,2,3,4,5 each one cycle after read, dout_valid pulses 5 times, count 5->0, empty_flag=1.
REQ-037 DEPTH=8: write 1..8 -> full_flag=1, count=8; 9th write (9) -> overflow=1, count stays 8; drain reads 1..8 in order; clr_err -> overflow=0.
REQ-038 Empty buffer: ren=1 -> underflow=1, dout_valid=0, count=0; same cycle wen=1 din=7 -> count=1, underflow=1.
REQ-039 Continuous wen=ren=1 for 20 cycles after 1 priming write, din=1..21 -> count stays 1, dout sequence 1..20, pointers wrap twice without loss.
REQ-040 FWFT=1, AFULL_TH=6, AEMPTY_TH=2: write 10..16 -> dout=10, dout_valid=1 after first write; almost_empty clears at count 3; almost_full sets at count 6; one read -> dout=11.
REQ-041 Write 3 words, assert rst_n=0 one cycle with wen=1 -> count=0, empty_flag=1, dout_valid=0; subsequent write 42 then read returns 42.

Source files
------------

// File: rtl/param_ring_buffer.sv
// Single-clock parameterised ring buffer with occupancy flags, sticky
// overflow/underflow errors, and a selectable registered or FWFT read port.
module param_ring_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic                       ren,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       clr_err,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       full_flag,
  output logic                       empty_flag,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Handshake: a write is taken when wen && !full_flag, a read when
  // ren && !empty_flag; a rejected request changes nothing but its sticky
  // error flag, and the two directions are independent within a cycle.
  assign wr_ok = wen && !full_flag;
  assign rd_ok = ren && !empty_flag;

  assign full_flag    = (count == DEPTH_C);
  assign empty_flag   = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh error in the clearing cycle takes priority over the clear.
      if (wen && full_flag)  overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (ren && empty_flag) underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty.
      assign dout       = empty_flag ? '0 : mem[rptr];
      assign dout_valid = !empty_flag;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_r;
      logic                  dout_valid_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_r       <= '0;
          dout_valid_r <= 1'b0;
        end else begin
          dout_valid_r <= rd_ok;
          if (rd_ok) dout_r <= mem[rptr];
        end
      end

      assign dout       = dout_r;
      assign dout_valid = dout_valid_r;
    end
  endgenerate

endmodule
